mem_wb_skid_stage: RTL and testbench

Parametrised MEM/WB pipeline stage with a ready/valid handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. It replaces a bare MEM->WB register when write-back can back-pressure, for example under a shared register-file port or a multi-cycle WB. Payload layout is unchanged: WB control bits, memory read data, ALU result and destination register index. Widths are generic.

---
 rtl/mem_wb_skid_stage.sv | 125 ++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with ready/valid handshake and a one-entry skid
// buffer, so write-back can back-pressure without a combinational ready path.
//
// state | meaning
// EMPTY | main invalid, skid invalid
// FULL  | main valid (drives outputs), skid invalid
// SKID  | main valid, skid holds the next entry; input not accepted
module mem_wb_skid_stage #(
  parameter int CTRL_W        = 2,
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter int CNT_W         = 8,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wb_en,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = CTRL_W + 2 * DATA_W + REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] main_q, skid_q, in_pl;
  logic          load_main_in, load_main_skid, load_skid;
  logic          clr_main, clr_skid;

  assign in_pl = {in_ctrl, in_mem_data, in_alu_result, in_rd};

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main       = 1'b0;
    clr_skid       = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      clr_main  = 1'b1;
      clr_skid  = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state_nxt    = FULL;
            load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (in_valid && out_ready) begin
            load_main_in = 1'b1;
          end else if (in_valid) begin
            state_nxt = SKID;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_nxt = EMPTY;
            clr_main  = 1'b1;
          end
        end
        SKID: begin
          if (out_ready) begin
            state_nxt      = FULL;
            load_main_skid = 1'b1;
            clr_skid       = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in)
        main_q <= in_pl;
      else if (load_main_skid)
        main_q <= skid_q;
      else if (clr_main && CLEAR_PAYLOAD)
        main_q <= '0;
      if (load_skid)
        skid_q <= in_pl;
      else if (clr_skid && CLEAR_PAYLOAD)
        skid_q <= '0;
    end
  end

  // Counts cycles WB refuses a valid entry; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (startin)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != CNT_MAX))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign in_ready  = (state != SKID);
  assign out_valid = (state != EMPTY);
  assign {out_ctrl, out_mem_data, out_alu_result, out_rd} = main_q;
  assign out_wb_en = out_valid & out_ctrl[CTRL_W-1];

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed scenarios then random traffic, all
// compared each cycle against a two-deep queue model of the stage.
module tb_mem_wb_skid_stage;

  localparam int CTRL_W = 2;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              startin, flush, in_valid, in_ready, out_valid, out_ready, out_wb_en;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_mem_data, in_alu_result, out_mem_data, out_alu_result;
  logic [REG_W-1:0]  in_rd, out_rd;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  mem_wb_skid_stage #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W), .CLEAR_PAYLOAD(1'b1)
  ) dut (
    .clk(clk), .startin(startin), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_mem_data(in_mem_data), .in_alu_result(in_alu_result), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_mem_data(out_mem_data), .out_alu_result(out_alu_result), .out_rd(out_rd),
    .out_wb_en(out_wb_en), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rd;
  } ent_t;

  ent_t q[$];
  int   cnt_m = 0;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] a, input logic [4:0] r);
    in_valid      = v;
    in_ctrl       = c;
    in_alu_result = a;
    in_mem_data   = a ^ 32'hA5A5_0000;
    in_rd         = r;
  endtask

  task automatic compare_all();
    ent_t e;
    bit   v;
    v = (q.size() > 0);
    e = '0;
    if (v) e = q[0];
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
    chk("out_mem_data", 64'(out_mem_data), 64'(e.mem));
    chk("out_alu_result", 64'(out_alu_result), 64'(e.alu));
    chk("out_rd", 64'(out_rd), 64'(e.rd));
    chk("out_wb_en", 64'(out_wb_en), 64'(v && e.ctrl[CTRL_W-1]));
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
    chk("no_skid_without_main", 64'(!in_ready && !out_valid), 64'(0));
  endtask

  // Stage behaves as a FIFO of depth two whose head is presented to WB.
  task automatic model_step();
    bit mv, mr;
    ent_t e;
    mv = (q.size() > 0);
    mr = (q.size() < 2);
    if (startin) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (mv && !out_ready && cnt_m < CNT_MAX) cnt_m++;
      if (flush) begin
        q.delete();
      end else begin
        if (mv && out_ready) e = q.pop_front();
        if (in_valid && mr) q.push_back(ent_t'{in_ctrl, in_mem_data, in_alu_result, in_rd});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    startin = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 2'b10, 32'h99, 5'd9);
    tick(); tick();
    startin = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    chk_en = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    chk("rst_payload", 64'({out_ctrl, out_rd, out_alu_result}), 64'(0));

    // streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b10, 32'h10 + 32'(i), 5'(i));
      tick();
      chk("stream_alu", 64'(out_alu_result), 64'(32'h10 + 32'(i)));
      chk("stream_wb_en", 64'(out_wb_en), 64'(1));
    end
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    tick();

    // back-pressure
    drive(1'b1, 2'b10, 32'hA, 5'd1);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 32'hB, 5'd2);
    tick();
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_head_a", 64'(out_alu_result), 64'(32'hA));
    drive(1'b1, 2'b10, 32'hC, 5'd3);
    tick(); tick();
    chk("bp_stall3", 64'(stall_cnt), 64'(3));
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", 64'(out_alu_result), 64'(32'hB));
    tick();
    chk("bp_head_c", 64'(out_alu_result), 64'(32'hC));
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    tick();

    // flush while in SKID
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 32'hE, 5'd4);
    tick();
    drive(1'b1, 2'b10, 32'hF, 5'd5);
    tick();
    flush = 1'b1;
    drive(1'b1, 2'b10, 32'hD, 5'd6);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    chk("flush_payload", 64'(out_alu_result), 64'(0));
    out_ready = 1'b1;
    tick();
    chk("flush_no_d", 64'(out_alu_result == 32'hD), 64'(0));

    // saturation
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h12, 5'd7);
    tick();
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    repeat (20) tick();
    chk("sat_stall", 64'(stall_cnt), 64'(CNT_MAX));

    // reset beats flush mid-stall
    drive(1'b1, 2'b10, 32'h77, 5'd8);
    startin = 1'b1; flush = 1'b1;
    tick();
    startin = 1'b0; flush = 1'b0;
    chk("rp_valid", 64'(out_valid), 64'(0));
    chk("rp_stall", 64'(stall_cnt), 64'(0));
    chk("rp_in_ready", 64'(in_ready), 64'(1));
    chk("rp_payload", 64'({out_ctrl, out_rd, out_alu_result, out_mem_data}), 64'(0));
    chk("rp_wb_en", 64'(out_wb_en), 64'(0));
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 32'h55, 5'd10);
    tick();
    chk("rp_next_valid", 64'(out_valid), 64'(1));
    chk("rp_next_alu", 64'(out_alu_result), 64'(32'h55));
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    tick();

    // random traffic
    repeat (600) begin
      in_valid      = 1'($urandom_range(1, 0));
      out_ready     = ($urandom_range(3, 0) != 0);
      flush         = ($urandom_range(15, 0) == 0);
      startin       = ($urandom_range(63, 0) == 0);
      in_ctrl       = 2'($urandom_range(3, 0));
      in_mem_data   = $urandom;
      in_alu_result = $urandom;
      in_rd         = 5'($urandom_range(31, 0));
      tick();
    end
    startin = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
